// File: rtl/sc_scbc_urc_pkg.sv
// ULPI register controller shared types.
// FSM states, TX command prefixes and command-byte helper.
package sc_scbc_urc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    EXTA,
    WDAT,
    STP,
    TURN,
    RDAT,
    TURNB,
    ABORT,
    DONE
  } urcState_t;

  localparam logic [1:0] ULPI_TXCMD_REGWR = 2'b10;
  localparam logic [1:0] ULPI_TXCMD_REGRD = 2'b11;
  localparam logic [5:0] ULPI_EXTADDR     = 6'h2F;

  function automatic logic is_ext(input logic [7:0] addr);
    return addr >= 8'h2F;
  endfunction

  function automatic logic [7:0] cmd_byte(
    input logic [7:0] addr,
    input logic       rd
  );
    logic [1:0] pfx;
    logic [5:0] a;
    pfx = rd ? ULPI_TXCMD_REGRD : ULPI_TXCMD_REGWR;
    a   = is_ext(addr) ? ULPI_EXTADDR : addr[5:0];
    return {pfx, a};
  endfunction

endpackage

// File: rtl/sc_scbc_urc.sv
// ULPI register controller: turns ULLA requests into
// RegWrite/RegRead bus transactions with timeout and abort.
module sc_scbc_urc
  import sc_scbc_urc_pkg::*;
#(
  parameter int NXT_TIMEOUT = 255
) (
  input  logic       ULPICLK,
  input  logic       ULPIRST,
  input  logic       ULLA_REQ,
  output logic       ULLA_ACK,
  input  logic [7:0] ULLA_ADDR,
  input  logic       ULLA_WR0RD1,
  input  logic [7:0] ULLA_WRDATA,
  output logic [7:0] URC_DATA,
  output logic       URC_ERR,
  input  logic       LINK_IDLE,
  output logic       URC_BUSY,
  input  logic       ULPI_DIR,
  input  logic       ULPI_NXT,
  output logic       ULPI_STP,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DATA_OE
);

  localparam int CW = $clog2(NXT_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(NXT_TIMEOUT - 1);

  urcState_t     state;
  logic [CW-1:0] cnt;
  logic [7:0]    addr_q;
  logic [7:0]    wdat_q;
  logic          rd_q;
  logic          drive;
  logic          to_hit;

  assign ULPI_DATA_OE = drive & ~ULPI_DIR;
  assign to_hit       = (cnt == TO_LAST);

  always_ff @(posedge ULPICLK) begin
    if (ULPIRST) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wdat_q      <= '0;
      rd_q        <= 1'b0;
      drive       <= 1'b0;
      ULLA_ACK    <= 1'b0;
      URC_DATA    <= '0;
      URC_ERR     <= 1'b0;
      URC_BUSY    <= 1'b0;
      ULPI_STP    <= 1'b0;
      ULPI_DATA_O <= '0;
    end else begin
      cnt      <= '0;
      ULLA_ACK <= 1'b0;
      ULPI_STP <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ULLA_REQ && LINK_IDLE && !ULPI_DIR) begin
            state       <= CMD;
            addr_q      <= ULLA_ADDR;
            wdat_q      <= ULLA_WRDATA;
            rd_q        <= ULLA_WR0RD1;
            drive       <= 1'b1;
            URC_BUSY    <= 1'b1;
            ULPI_DATA_O <= cmd_byte(ULLA_ADDR, ULLA_WR0RD1);
          end
        end
        CMD, EXTA, WDAT: begin
          // PHY wins a DIR/NXT collision
          if (ULPI_DIR) begin
            state       <= ABORT;
            drive       <= 1'b0;
            ULPI_DATA_O <= '0;
          end else if (ULPI_NXT) begin
            if (state == CMD && is_ext(addr_q)) begin
              state       <= EXTA;
              ULPI_DATA_O <= addr_q;
            end else if (state == WDAT) begin
              state       <= STP;
              ULPI_STP    <= 1'b1;
              ULPI_DATA_O <= '0;
            end else if (rd_q) begin
              state       <= TURN;
              drive       <= 1'b0;
              ULPI_DATA_O <= '0;
            end else begin
              state       <= WDAT;
              ULPI_DATA_O <= wdat_q;
            end
          end else if (to_hit) begin
            state       <= DONE;
            drive       <= 1'b0;
            ULPI_DATA_O <= '0;
            ULLA_ACK    <= 1'b1;
            URC_ERR     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STP: begin
          state    <= DONE;
          drive    <= 1'b0;
          ULLA_ACK <= 1'b1;
          URC_ERR  <= 1'b0;
        end
        TURN: begin
          if (ULPI_DIR) begin
            state <= RDAT;
          end else if (to_hit) begin
            state    <= DONE;
            ULLA_ACK <= 1'b1;
            URC_ERR  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RDAT: begin
          if (ULPI_DIR && !ULPI_NXT) begin
            state    <= TURNB;
            URC_DATA <= ULPI_DATA_I;
          end else begin
            state <= ABORT;
          end
        end
        TURNB: begin
          if (!ULPI_DIR) begin
            state    <= DONE;
            ULLA_ACK <= 1'b1;
            URC_ERR  <= 1'b0;
          end
        end
        ABORT: begin
          // request stays high, so IDLE retries it
          if (!ULPI_DIR) begin
            state    <= IDLE;
            URC_BUSY <= 1'b0;
          end
        end
        DONE: begin
          state    <= IDLE;
          URC_BUSY <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          drive    <= 1'b0;
          URC_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_scbc_urc.sv
// Directed bench for sc_scbc_urc: table of register
// accesses plus abort, timeout and reset sequences.
module tb_sc_scbc_urc;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       ack;
  logic [7:0] addr;
  logic       rd;
  logic [7:0] wdata;
  logic [7:0] urc_data;
  logic       urc_err;
  logic       link_idle;
  logic       busy;
  logic       dir;
  logic       nxt;
  logic       stp;
  logic [7:0] di;
  logic [7:0] dout;
  logic       oe;

  int passed = 0;
  int total  = 0;
  int acks   = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (ack) acks++;

  sc_scbc_urc #(.NXT_TIMEOUT(8)) dut (
    .ULPICLK      (clk),
    .ULPIRST      (rst),
    .ULLA_REQ     (req),
    .ULLA_ACK     (ack),
    .ULLA_ADDR    (addr),
    .ULLA_WR0RD1  (rd),
    .ULLA_WRDATA  (wdata),
    .URC_DATA     (urc_data),
    .URC_ERR      (urc_err),
    .LINK_IDLE    (link_idle),
    .URC_BUSY     (busy),
    .ULPI_DIR     (dir),
    .ULPI_NXT     (nxt),
    .ULPI_STP     (stp),
    .ULPI_DATA_I  (di),
    .ULPI_DATA_O  (dout),
    .ULPI_DATA_OE (oe)
  );

  typedef struct {
    logic [7:0] addr;
    logic       rd;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         dly;
    logic [7:0] cmd;
    logic       ext;
  } vec_t;

  vec_t vt[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive_byte(input string nm, input logic [7:0] b,
                            input int dly);
    chk({nm, " byte"}, dout, b);
    chk({nm, " oe"}, oe, 1);
    repeat (dly) step();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
  endtask

  task automatic finish_wr(input string nm, input int a0);
    chk({nm, " stp"}, stp, 1);
    chk({nm, " stp data"}, dout, 0);
    step();
    chk({nm, " ack"}, ack, 1);
    chk({nm, " err"}, urc_err, 0);
    req = 1'b0;
    step();
    chk({nm, " ack count"}, acks - a0, 1);
    chk({nm, " busy idle"}, busy, 0);
  endtask

  initial begin
    int a0;
    logic [7:0] keep;

    vt[0] = '{8'h0A, 1'b0, 8'h45, 8'h00, 2, 8'h8A, 1'b0};
    vt[1] = '{8'h16, 1'b1, 8'h00, 8'h5A, 1, 8'hD6, 1'b0};
    vt[2] = '{8'h85, 1'b1, 8'h00, 8'h3C, 0, 8'hEF, 1'b1};
    vt[3] = '{8'h2F, 1'b0, 8'h77, 8'h00, 3, 8'hAF, 1'b1};
    vt[4] = '{8'h2E, 1'b0, 8'h12, 8'h00, 0, 8'hAE, 1'b0};
    vt[5] = '{8'h00, 1'b1, 8'h00, 8'hFF, 4, 8'hC0, 1'b0};
    vt[6] = '{8'hFF, 1'b0, 8'h00, 8'h00, 1, 8'hAF, 1'b1};

    rst = 1'b1; req = 1'b0; addr = '0; rd = 1'b0; wdata = '0;
    link_idle = 1'b1; dir = 1'b0; nxt = 1'b0; di = '0;
    repeat (3) step();
    chk("rst ack", ack, 0);
    chk("rst data", urc_data, 0);
    chk("rst err", urc_err, 0);
    chk("rst busy", busy, 0);
    chk("rst stp", stp, 0);
    chk("rst dout", dout, 0);
    chk("rst oe", oe, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      a0 = acks;
      addr = vt[i].addr; rd = vt[i].rd; wdata = vt[i].wdata;
      req = 1'b1;
      step();
      chk({nm, " busy"}, busy, 1);
      drive_byte({nm, " cmd"}, vt[i].cmd, vt[i].dly);
      if (vt[i].ext) drive_byte({nm, " ext"}, vt[i].addr, vt[i].dly);
      if (!vt[i].rd) begin
        drive_byte({nm, " wdat"}, vt[i].wdata, vt[i].dly);
        finish_wr(nm, a0);
      end else begin
        chk({nm, " turn oe"}, oe, 0);
        dir = 1'b1;
        step();
        di = vt[i].rdata;
        step();
        di = 8'h00;
        dir = 1'b0;
        chk({nm, " no early ack"}, ack, 0);
        step();
        chk({nm, " ack"}, ack, 1);
        chk({nm, " rdata"}, urc_data, vt[i].rdata);
        chk({nm, " err"}, urc_err, 0);
        req = 1'b0;
        step();
        chk({nm, " ack count"}, acks - a0, 1);
      end
      step();
    end

    // RX pre-emption during CMD, then retry
    a0 = acks;
    addr = 8'h04; rd = 1'b0; wdata = 8'h01; req = 1'b1;
    step();
    chk("abort cmd", dout, 8'h84);
    dir = 1'b1;
    #1;
    chk("abort oe", oe, 0);
    repeat (3) step();
    chk("abort no ack", acks - a0, 0);
    dir = 1'b0;
    step();
    step();
    drive_byte("retry cmd", 8'h84, 1);
    drive_byte("retry wdat", 8'h01, 0);
    finish_wr("retry", a0);
    step();

    // NXT never arrives
    a0 = acks;
    keep = urc_data;
    addr = 8'h10; rd = 1'b0; wdata = 8'h20; req = 1'b1;
    step();
    repeat (7) step();
    chk("to early ack", acks - a0, 0);
    step();
    chk("to ack", ack, 1);
    chk("to err", urc_err, 1);
    chk("to data kept", urc_data, keep);
    req = 1'b0;
    step();
    step();
    chk("to busy", busy, 0);
    chk("to ack count", acks - a0, 1);

    // reset in WDAT, then LINK_IDLE hold-off
    addr = 8'h0A; rd = 1'b0; wdata = 8'h45; req = 1'b1;
    step();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    chk("rstw wdat", dout, 8'h45);
    rst = 1'b1;
    step();
    chk("rstw oe", oe, 0);
    chk("rstw stp", stp, 0);
    chk("rstw busy", busy, 0);
    chk("rstw err", urc_err, 0);
    rst = 1'b0;
    link_idle = 1'b0;
    a0 = acks;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold oe", oe, 0);
      chk("hold busy", busy, 0);
    end
    link_idle = 1'b1;
    step();
    drive_byte("resume cmd", 8'h8A, 0);
    drive_byte("resume wdat", 8'h45, 0);
    finish_wr("resume", a0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
